// File: rtl/watch_set_pkg.sv
// Shared encodings for the watch time-setting control unit: FSM states,
// button bit positions and the default inactivity timeout.
package watch_set_pkg;

    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_EDIT = 2'b01;
    localparam logic [1:0] ST_HOLD = 2'b10;

    localparam int BTN_R = 0;
    localparam int BTN_L = 1;
    localparam int BTN_U = 2;
    localparam int BTN_D = 3;

    localparam int TIMEOUT_SEC_DEF = 10;

endpackage

// File: rtl/watch_set_cu_if.sv
// Button/switch inputs and field-select/strobe outputs of watch_set_cu.
// master = stimulus side (button logic), slave = the control unit.
interface watch_set_cu_if #(
    parameter int NUM_FIELDS = 3
);
    logic                  i_tick_1hz;
    logic                  i_select;
    logic [3:0]            i_btn;
    logic                  o_edit;
    logic [NUM_FIELDS-1:0] o_field_sel;
    logic                  o_inc;
    logic                  o_dec;
    logic                  o_blink;

    modport master (
        output i_tick_1hz, i_select, i_btn,
        input  o_edit, o_field_sel, o_inc, o_dec, o_blink
    );

    modport slave (
        input  i_tick_1hz, i_select, i_btn,
        output o_edit, o_field_sel, o_inc, o_dec, o_blink
    );
endinterface

// File: rtl/watch_set_timer.sv
// Inactivity counter for edit mode: counts ticks, cleared by activity,
// pulses expire for one cycle on the tick that reaches TIMEOUT_SEC.
module watch_set_timer #(
    parameter int TIMEOUT_SEC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expire
);
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_SEC - 1);

    logic [7:0] cnt_r;

    // Expiry fires on the counting tick itself; a clear in the same cycle wins.
    always_comb begin
        expire = tick & ~clr & (cnt_r == LAST_CNT);
    end

    // Tick counter; wraps to zero when it expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= 8'd0;
        end else if (clr) begin
            cnt_r <= 8'd0;
        end else if (tick) begin
            if (cnt_r == LAST_CNT) begin
                cnt_r <= 8'd0;
            end else begin
                cnt_r <= cnt_r + 8'd1;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/watch_set_cu.sv
// Time-setting control unit: field navigation, inc/dec strobes and blink phase.
// Optional inactivity auto-exit when WATCH_SET_TIMEOUT_EN is defined.
module watch_set_cu
    import watch_set_pkg::*;
#(
    parameter int NUM_FIELDS = 3
`ifdef WATCH_SET_TIMEOUT_EN
    , parameter int TIMEOUT_SEC = TIMEOUT_SEC_DEF
`endif
) (
    input  logic          clk,
    input  logic          rst,
    watch_set_cu_if.slave bus
);
    localparam int FIDX_W = $clog2(NUM_FIELDS);
    localparam logic [FIDX_W-1:0] FIDX_ZERO = FIDX_W'(0);
    localparam logic [FIDX_W-1:0] FIDX_ONE  = FIDX_W'(1);
    localparam logic [FIDX_W-1:0] FIDX_MAX  = FIDX_W'(NUM_FIELDS - 1);

    function automatic logic [NUM_FIELDS-1:0] field_onehot(input logic [FIDX_W-1:0] idx);
        logic [NUM_FIELDS-1:0] v;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            v[i] = (idx == FIDX_W'(i));
        end
        return v;
    endfunction

    logic [1:0]            state_r, state_s;
    logic [FIDX_W-1:0]     fidx_r, fidx_s;
    logic                  blink_r, blink_s;
    logic                  edit_r;
    logic [NUM_FIELDS-1:0] field_sel_r, field_sel_s;
    logic                  inc_r, inc_s;
    logic                  dec_r, dec_s;
    logic                  nav_s, mv_l_s, mv_r_s, inc_req_s, dec_req_s, act_s;
    logic                  expire_s;

    // Button decode: navigation masks up/down, opposing pairs cancel.
    always_comb begin
        nav_s     = bus.i_btn[BTN_L] | bus.i_btn[BTN_R];
        mv_l_s    = bus.i_btn[BTN_L] & ~bus.i_btn[BTN_R];
        mv_r_s    = bus.i_btn[BTN_R] & ~bus.i_btn[BTN_L];
        inc_req_s = ~nav_s & bus.i_btn[BTN_U] & ~bus.i_btn[BTN_D];
        dec_req_s = ~nav_s & bus.i_btn[BTN_D] & ~bus.i_btn[BTN_U];
        act_s     = mv_l_s | mv_r_s | inc_req_s | dec_req_s;
    end

`ifdef WATCH_SET_TIMEOUT_EN
    logic timer_clr_s;
    logic timer_tick_s;

    // Timer runs only while editing; any accepted button restarts it.
    always_comb begin
        timer_clr_s  = act_s | (state_r != ST_EDIT);
        timer_tick_s = bus.i_tick_1hz & (state_r == ST_EDIT);
    end

    watch_set_timer #(
        .TIMEOUT_SEC (TIMEOUT_SEC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr_s),
        .tick   (timer_tick_s),
        .expire (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next state, field index, blink phase and strobes.
    always_comb begin
        state_s = state_r;
        fidx_s  = fidx_r;
        blink_s = 1'b1;
        inc_s   = 1'b0;
        dec_s   = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (bus.i_select) begin
                    state_s = ST_EDIT;
                    fidx_s  = FIDX_ZERO;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_EDIT: begin
                if (!bus.i_select) begin
                    state_s = ST_RUN;
                end else if (act_s) begin
                    if (mv_l_s) begin
                        fidx_s = (fidx_r == FIDX_MAX) ? FIDX_ZERO : fidx_r + FIDX_ONE;
                    end else if (mv_r_s) begin
                        fidx_s = (fidx_r == FIDX_ZERO) ? FIDX_MAX : fidx_r - FIDX_ONE;
                    end else begin
                        fidx_s = fidx_r;
                    end
                    inc_s = inc_req_s;
                    dec_s = dec_req_s;
                end else if (expire_s) begin
                    state_s = ST_HOLD;
                end else if (bus.i_tick_1hz) begin
                    blink_s = ~blink_r;
                end else begin
                    blink_s = blink_r;
                end
            end
            ST_HOLD: begin
                if (!bus.i_select) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s = ST_RUN;
                fidx_s  = FIDX_ZERO;
            end
        endcase
    end

    // Field-select decode of the next index; blank outside edit.
    always_comb begin
        if (state_s == ST_EDIT) begin
            field_sel_s = field_onehot(fidx_s);
        end else begin
            field_sel_s = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            fidx_r      <= FIDX_ZERO;
            blink_r     <= 1'b1;
            edit_r      <= 1'b0;
            field_sel_r <= '0;
            inc_r       <= 1'b0;
            dec_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            fidx_r      <= fidx_s;
            blink_r     <= blink_s;
            edit_r      <= (state_s == ST_EDIT);
            field_sel_r <= field_sel_s;
            inc_r       <= inc_s;
            dec_r       <= dec_s;
        end
    end

    assign bus.o_edit      = edit_r;
    assign bus.o_field_sel = field_sel_r;
    assign bus.o_inc       = inc_r;
    assign bus.o_dec       = dec_r;
    assign bus.o_blink     = blink_r;
endmodule

// File: tb/tb_watch_set_cu.sv
// Directed and randomized checks of watch_set_cu against a behavioural model.
// Define WATCH_SET_TIMEOUT_EN to exercise the inactivity-timeout build.
module tb_watch_set_cu;
    localparam int NF = 3;
`ifdef WATCH_SET_TIMEOUT_EN
    localparam int TO = 3;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    watch_set_cu_if #(.NUM_FIELDS(NF)) bus ();

    watch_set_cu #(
        .NUM_FIELDS (NF)
`ifdef WATCH_SET_TIMEOUT_EN
        , .TIMEOUT_SEC (TO)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: editing/holding flags, field number, blink, idle ticks.
    bit m_edit, m_hold, m_blink, m_inc, m_dec;
    int m_field, m_idle;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edit = 1'b0; m_hold = 1'b0; m_blink = 1'b1;
        m_inc = 1'b0; m_dec = 1'b0; m_field = 0; m_idle = 0;
    endtask

    task automatic model_step(input bit tick, input bit sel, input bit [3:0] btn);
        bit r, l, u, d, acted;
        r = btn[0]; l = btn[1]; u = btn[2]; d = btn[3];
        m_inc = 1'b0; m_dec = 1'b0; acted = 1'b0;
        if (m_hold) begin
            if (!sel) m_hold = 1'b0;
        end else if (!m_edit) begin
            if (sel) begin
                m_edit = 1'b1; m_field = 0; m_blink = 1'b1; m_idle = 0;
            end
        end else if (!sel) begin
            m_edit = 1'b0; m_blink = 1'b1; m_idle = 0;
        end else begin
            if (l || r) begin
                if (l && !r) begin m_field = (m_field + 1) % NF; acted = 1'b1; end
                if (r && !l) begin m_field = (m_field + NF - 1) % NF; acted = 1'b1; end
            end else if (u != d) begin
                m_inc = u; m_dec = d; acted = 1'b1;
            end
            if (acted) begin
                m_blink = 1'b1; m_idle = 0;
            end else if (tick) begin
                m_blink = !m_blink;
`ifdef WATCH_SET_TIMEOUT_EN
                m_idle++;
                if (m_idle == TO) begin
                    m_edit = 1'b0; m_hold = 1'b1; m_blink = 1'b1; m_idle = 0;
                end
`endif
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] exp_sel;
        exp_sel = m_edit ? (32'd1 << m_field) : 32'd0;
        check({tag, ".edit"},  32'(bus.o_edit), 32'(m_edit));
        check({tag, ".fsel"},  32'(bus.o_field_sel), exp_sel);
        check({tag, ".inc"},   32'(bus.o_inc), 32'(m_inc));
        check({tag, ".dec"},   32'(bus.o_dec), 32'(m_dec));
        check({tag, ".blink"}, 32'(bus.o_blink), m_edit ? 32'(m_blink) : 32'd1);
    endtask

    task automatic step(input string tag, input bit tick, input bit sel, input bit [3:0] btn);
        bus.i_tick_1hz = tick;
        bus.i_select   = sel;
        bus.i_btn      = btn;
        @(posedge clk);
        model_step(tick, sel, btn);
        #1;
        check_all(tag);
    endtask

    localparam bit [3:0] B_R = 4'b0001, B_L = 4'b0010, B_U = 4'b0100, B_D = 4'b1000, B_0 = 4'b0000;

    initial begin
        bit sel_r;
        rst = 1'b1;
        bus.i_tick_1hz = 1'b0; bus.i_select = 1'b0; bus.i_btn = B_0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) step("idle", 1'b0, 1'b0, B_0);

        step("enter", 1'b0, 1'b1, B_0);
        check("enter_const", 32'(bus.o_field_sel), 32'd1);
        step("left1", 1'b0, 1'b1, B_L);
        check("left1_const", 32'(bus.o_field_sel), 32'd2);
        step("left2", 1'b0, 1'b1, B_L);
        check("left2_const", 32'(bus.o_field_sel), 32'd4);
        step("left3", 1'b0, 1'b1, B_L);
        check("left3_const", 32'(bus.o_field_sel), 32'd1);
        step("right_wrap", 1'b0, 1'b1, B_R);
        check("right_wrap_const", 32'(bus.o_field_sel), 32'd4);
        step("left_right", 1'b0, 1'b1, B_L | B_R);
        check("left_right_const", 32'(bus.o_field_sel), 32'd4);
        step("right_to_f1", 1'b0, 1'b1, B_R);
        step("up", 1'b0, 1'b1, B_U);
        check("up_inc_const", 32'(bus.o_inc), 32'd1);
        check("up_fsel_const", 32'(bus.o_field_sel), 32'd2);
        step("after_up", 1'b0, 1'b1, B_0);
        check("after_up_const", 32'(bus.o_inc), 32'd0);
        step("up_down", 1'b0, 1'b1, B_U | B_D);
        step("left_up", 1'b0, 1'b1, B_L | B_U);
        check("left_up_inc_const", 32'(bus.o_inc), 32'd0);
        step("down", 1'b1, 1'b1, B_D);
        step("down2", 1'b0, 1'b1, B_D);
        step("drop_with_up", 1'b0, 1'b0, B_U);
        check("drop_edit_const", 32'(bus.o_edit), 32'd0);

`ifdef WATCH_SET_TIMEOUT_EN
        step("to_enter", 1'b0, 1'b1, B_0);
        step("to_t1", 1'b1, 1'b1, B_0);
        step("to_gap1", 1'b0, 1'b1, B_0);
        step("to_t2", 1'b1, 1'b1, B_0);
        step("to_gap2", 1'b0, 1'b1, B_0);
        step("to_t3", 1'b1, 1'b1, B_0);
        check("to_hold_const", 32'(bus.o_edit), 32'd0);
        step("to_hold_sel", 1'b0, 1'b1, B_U);
        step("to_hold_sel2", 1'b1, 1'b1, B_0);
        step("to_release", 1'b0, 1'b0, B_0);
        step("to_reenter", 1'b0, 1'b1, B_0);
        check("to_reenter_const", 32'(bus.o_field_sel), 32'd1);
        step("to_r_t1", 1'b1, 1'b1, B_0);
        step("to_r_t2", 1'b1, 1'b1, B_0);
        step("to_r_btn", 1'b0, 1'b1, B_U);
        step("to_r_t3", 1'b1, 1'b1, B_0);
        step("to_r_t4", 1'b1, 1'b1, B_0);
        check("to_restart_const", 32'(bus.o_edit), 32'd1);
        step("to_r_t5", 1'b1, 1'b1, B_0);
        check("to_restart_hold_const", 32'(bus.o_edit), 32'd0);
        step("to_exit", 1'b0, 1'b0, B_0);
`else
        step("nt_enter", 1'b0, 1'b1, B_0);
        for (int i = 0; i < 20; i++) step("nt_tick", 1'b1, 1'b1, B_0);
        check("nt_persist_const", 32'(bus.o_edit), 32'd1);
        step("nt_exit", 1'b0, 1'b0, B_0);
`endif

        step("rm_enter", 1'b0, 1'b1, B_0);
        step("rm_l1", 1'b0, 1'b1, B_L);
        step("rm_l2", 1'b0, 1'b1, B_L);
        step("rm_tick", 1'b1, 1'b1, B_0);
        check("rm_blink_low_const", 32'(bus.o_blink), 32'd0);
        bus.i_tick_1hz = 1'b0; bus.i_btn = B_U;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        check("rst_mid_blink_const", 32'(bus.o_blink), 32'd1);
        @(posedge clk);
        #1;
        check_all("rst_held");
        bus.i_select = 1'b0; bus.i_btn = B_0;
        rst = 1'b0;

        sel_r = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            bit       tk;
            bit [3:0] bt;
            if ($urandom_range(0, 39) == 0) sel_r = !sel_r;
            tk = ($urandom_range(0, 4) == 0);
            bt = ($urandom_range(0, 1) == 0) ? B_0 : 4'($urandom_range(0, 15));
            step($sformatf("rand%0d", i), tk, sel_r, bt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
